// File: rtl/frog_pkg.sv
// Shared definitions for the frog button path.
//
// Holds the direction bit order used by the button conditioner and by the
// frog movement block, the default debounce length, and the function that
// cancels opposing move requests.
//
// Contents:
//   NUM_DIRS           number of direction buttons (4)
//   DIR_UP..DIR_RIGHT  bit index of each direction in every 4-bit mask
//   DB_CYCLES_DEFAULT  stable cycles needed to accept a level (10 ms @ 100 MHz)
//   dir_mask_t         one bit per direction
//   resolveMoves()     drops both bits of an opposing pair

package frog_pkg;

  localparam int NUM_DIRS  = 4;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int DB_CYCLES_DEFAULT = 1000000;

  typedef logic [NUM_DIRS-1:0] dir_mask_t;

  // Up+down cancels to nothing, as does left+right. The two axes are
  // independent, so a diagonal request (e.g. up+left) passes through whole.
  function automatic dir_mask_t resolveMoves(input dir_mask_t req);
    dir_mask_t res;
    res = req;
    if (req[DIR_UP] && req[DIR_DOWN]) begin
      res[DIR_UP]   = 1'b0;
      res[DIR_DOWN] = 1'b0;
    end
    if (req[DIR_LEFT] && req[DIR_RIGHT]) begin
      res[DIR_LEFT]  = 1'b0;
      res[DIR_RIGHT] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Button conditioner bus.
//
// Groups the per-frame button signals between the board/timing side and the
// conditioner so both ends agree on the direction bit order.
//
// Signals:
//   i_btn      raw asynchronous buttons, one bit per direction
//   i_animate  one-cycle end-of-frame strobe
//   i_freeze   discards all move requests while high
//   o_move     one-cycle move pulses, the cycle after a strobe
//   o_level    debounced pressed level, active-high
//
// Modports:
//   master  drives the inputs, observes the outputs (board side / bench)
//   slave   the conditioner itself

interface btn_cond_if;
  import frog_pkg::*;

  dir_mask_t i_btn;
  logic      i_animate;
  logic      i_freeze;
  dir_mask_t o_move;
  dir_mask_t o_level;

  modport master (
    output i_btn,
    output i_animate,
    output i_freeze,
    input  o_move,
    input  o_level
  );

  modport slave (
    input  i_btn,
    input  i_animate,
    input  i_freeze,
    output o_move,
    output o_level
  );

endinterface

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer.
//
// Brings one raw button into the clock domain, normalises it to active-high,
// and only accepts a level change once the synced input has disagreed with
// the current level for DB_CYCLES consecutive cycles. A 0->1 change of the
// accepted level is reported as a one-cycle press event in the same cycle the
// level register updates, so a strobe in that cycle can include it.
//
// Optional feature (macro BTN_REPEAT_EN): while the level is held, count
// frame strobes and emit synthetic press events after REPEAT_DELAY strobes,
// then every REPEAT_FRAMES strobes.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_btn         raw button pin
//   i_animate     frame strobe            (BTN_REPEAT_EN only)
//   i_freeze      clears the repeat count (BTN_REPEAT_EN only)
//   o_level       debounced pressed level
//   o_event       press event (plus repeat events with BTN_REPEAT_EN)

module btn_debounce
  import frog_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW = 1'b1
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_FRAMES = 6
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
`ifdef BTN_REPEAT_EN
  input  logic i_animate,
  input  logic i_freeze,
`endif
  output logic o_level,
  output logic o_event
);

  localparam int              CntW        = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax      = CntW'(DB_CYCLES - 1);
  localparam logic            RawReleased = ACTIVE_LOW;

  logic            sync1_q;
  logic            sync2_q;
  logic            pressed;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            level_q;
  logic            level_d;
  logic            settled;
  logic            pressEvent;

  // Two-flop synchroniser. Both stages reset to the released pin value so
  // leaving reset never looks like a press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= RawReleased;
      sync2_q <= RawReleased;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ ACTIVE_LOW;

  // Any agreement with the current level restarts the count, so only an
  // uninterrupted run of DB_CYCLES disagreeing samples flips the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    settled = 1'b0;
    if (pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      level_d = ~level_q;
      settled = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Only the release->press transition is an event; releases are silent.
  assign pressEvent = settled & ~level_q;
  assign o_level    = level_q;

`ifdef BTN_REPEAT_EN
  localparam int RptMax = (REPEAT_DELAY > REPEAT_FRAMES) ? REPEAT_DELAY : REPEAT_FRAMES;
  localparam int RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_q;
  logic [RptW-1:0] rpt_d;
  logic [RptW-1:0] rptInc;
  logic            armed_q;
  logic            armed_d;
  logic            rptEvent;

  assign rptInc = rpt_q + 1'b1;

  // Strobes counted while held. Before the first repeat the target is
  // REPEAT_DELAY; once armed the count restarts and targets REPEAT_FRAMES.
  // The counter wraps at its target, so it never exceeds RptMax.
  always_comb begin
    rpt_d    = rpt_q;
    armed_d  = armed_q;
    rptEvent = 1'b0;
    if (!level_q || i_freeze) begin
      rpt_d   = '0;
      armed_d = 1'b0;
    end else if (i_animate) begin
      if (!armed_q && (rptInc == RptW'(REPEAT_DELAY))) begin
        rptEvent = 1'b1;
        armed_d  = 1'b1;
        rpt_d    = '0;
      end else if (armed_q && (rptInc == RptW'(REPEAT_FRAMES))) begin
        rptEvent = 1'b1;
        rpt_d    = '0;
      end else begin
        rpt_d = rptInc;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rpt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      armed_q <= armed_d;
    end
  end

  assign o_event = pressEvent | rptEvent;
`else
  assign o_event = pressEvent;
`endif

endmodule

// File: rtl/btn_cond.sv
// Frog direction button conditioner (top level).
//
// Debounces the four direction buttons and converts presses into move
// requests that are held pending until the next end-of-frame strobe, so the
// frog steps at most once per direction per frame. On a strobe the pending
// set (plus any press completing in that very cycle) is resolved for
// opposing directions and issued as a registered one-cycle move pulse.
// Freeze discards everything pending and suppresses moves while the
// debounced levels keep tracking.
//
// Optional feature (macro BTN_REPEAT_EN): held buttons auto-repeat, see
// btn_debounce.
//
// Ports:
//   i_clk  system clock (100 MHz)
//   i_rst  asynchronous active-high reset
//   bus    btn_cond_if.slave: i_btn, i_animate, i_freeze in; o_move, o_level out

module btn_cond
  import frog_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_FRAMES = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  btn_cond_if.slave   bus
);

  dir_mask_t level;
  dir_mask_t pressEvt;
  dir_mask_t pend_q;
  dir_mask_t pend_d;
  dir_mask_t move_q;
  dir_mask_t move_d;

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES     (DB_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_FRAMES (REPEAT_FRAMES)
`endif
    ) u_debounce (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_btn     (bus.i_btn[g]),
`ifdef BTN_REPEAT_EN
      .i_animate (bus.i_animate),
      .i_freeze  (bus.i_freeze),
`endif
      .o_level   (level[g]),
      .o_event   (pressEvt[g])
    );
  end

  // Strobe: issue everything pending plus same-cycle presses, then start the
  // next frame empty. Between strobes presses accumulate, so repeated presses
  // of one button within a frame collapse into a single move.
  always_comb begin
    pend_d = pend_q;
    move_d = '0;
    if (bus.i_freeze) begin
      pend_d = '0;
    end else if (bus.i_animate) begin
      move_d = resolveMoves(pend_q | pressEvt);
      pend_d = '0;
    end else begin
      pend_d = pend_q | pressEvt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q <= '0;
      move_q <= '0;
    end else begin
      pend_q <= pend_d;
      move_q <= move_d;
    end
  end

  assign bus.o_move  = move_q;
  assign bus.o_level = level;

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond with DB_CYCLES=8, active-low buttons and
// a frame strobe every 100 cycles. Build with BTN_REPEAT_EN defined to also
// exercise auto-repeat (REPEAT_DELAY=3, REPEAT_FRAMES=2).

module tb_btn_cond;
  import frog_pkg::*;

  localparam int FRAME = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  btn_cond_if bus ();

  btn_cond #(
    .DB_CYCLES     (8),
    .ACTIVE_LOW    (1'b1),
    .REPEAT_DELAY  (3),
    .REPEAT_FRAMES (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // phase is the frame-relative index of the cycle currently being driven;
  // the strobe is driven during phase FRAME-1.
  int phase    = 0;
  int frameNum = 0;

  typedef struct {
    logic [3:0] move;
    int         frame;
  } pulse_t;

  pulse_t pulseLog[$];
  logic   animAtEdge = 1'b0;

  typedef struct {
    string      name;
    logic [3:0] press;
    logic [3:0] expMove;
  } vec_t;

  vec_t vecs[8];

  // Every move pulse is logged and must follow a sampled strobe.
  always @(posedge clk) animAtEdge <= bus.i_animate;

  always @(negedge clk) begin
    if (bus.o_move !== 4'b0000) begin
      pulseLog.push_back('{move: bus.o_move, frame: frameNum});
      checks++;
      if (animAtEdge !== 1'b1) begin
        failures++;
        $display("[TB] FAIL strobeAlign: o_move=%b seen with no strobe on the previous edge (frame %0d phase %0d), required 0000",
                 bus.o_move, frameNum, phase);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] raw);
    bus.i_btn = raw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase + 1) % FRAME;
    if (phase == 0) frameNum++;
    bus.i_animate = (phase == FRAME - 1);
  endtask

  task automatic waitPhase(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (phase != p && n < 2 * FRAME);
    if (phase != p) begin
      failures++;
      $display("[TB] FAIL waitPhase: actual phase=%0d required=%0d", phase, p);
    end
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int f0;
    logic bounceBad;

    vecs[0] = '{name: "up",         press: 4'b0001, expMove: 4'b0001};
    vecs[1] = '{name: "upDown",     press: 4'b0011, expMove: 4'b0000};
    vecs[2] = '{name: "upDownLeft", press: 4'b0111, expMove: 4'b0100};
    vecs[3] = '{name: "upLeft",     press: 4'b0101, expMove: 4'b0101};
    vecs[4] = '{name: "leftRight",  press: 4'b1100, expMove: 4'b0000};
    vecs[5] = '{name: "downRight",  press: 4'b1010, expMove: 4'b1010};
    vecs[6] = '{name: "all",        press: 4'b1111, expMove: 4'b0000};
    vecs[7] = '{name: "down",       press: 4'b0010, expMove: 4'b0010};

    bus.i_btn     = 4'hF;
    bus.i_animate = 1'b0;
    bus.i_freeze  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetLevel", bus.o_level, 4'b0000);
    checkOutput("resetMove", bus.o_move, 4'b0000);
    rst = 1'b0;
    phase = 0;
    frameNum = 0;

    // Table: press pattern in one frame, one resolved pulse, silent release.
    for (int i = 0; i < 8; i++) begin
      waitPhase(10);
      applyStimulus(~vecs[i].press);
      waitPhase(50);
      checkOutput({vecs[i].name, "_level"}, bus.o_level, vecs[i].press);
      pulseLog.delete();
      waitPhase(10);
      checkOutput({vecs[i].name, "_nPulses"}, pulseLog.size(), (vecs[i].expMove != 4'b0000) ? 1 : 0);
      if (pulseLog.size() > 0)
        checkOutput({vecs[i].name, "_move"}, pulseLog[0].move, vecs[i].expMove);
      applyStimulus(4'hF);
      waitPhase(50);
      checkOutput({vecs[i].name, "_released"}, bus.o_level, 4'b0000);
      pulseLog.delete();
      waitPhase(10);
      checkOutput({vecs[i].name, "_noReleasePulse"}, pulseLog.size(), 0);
    end

    // Clean press: exact level latency of 2 + DB_CYCLES.
    waitPhase(10);
    applyStimulus(4'b1110);
    waitPhase(19);
    checkOutput("clean_levelAt19", bus.o_level, 4'b0000);
    tick();
    checkOutput("clean_levelAt20", bus.o_level, 4'b0001);
    pulseLog.delete();
    waitPhase(10);
    checkOutput("clean_nPulses", pulseLog.size(), 1);
    if (pulseLog.size() > 0)
      checkOutput("clean_move", pulseLog[0].move, 4'b0001);
`ifndef BTN_REPEAT_EN
    pulseLog.delete();
    repeat (3) waitPhase(10);
    checkOutput("clean_heldNoRepeat", pulseLog.size(), 0);
`endif
    applyStimulus(4'hF);
    waitPhase(50);

    // Bounce: 5-cycle runs never reach the 8-cycle debounce.
    waitPhase(10);
    pulseLog.delete();
    bounceBad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k % 2 == 0) ? 4'b0111 : 4'b1111);
      repeat (5) begin
        tick();
        if (bus.o_level !== 4'b0000) bounceBad = 1'b1;
      end
    end
    waitPhase(10);
    checkOutput("bounce_levelStayed0", bounceBad, 1'b0);
    checkOutput("bounce_noPulse", pulseLog.size(), 0);

    // Freeze across a strobe after a right press: no pulse, nothing left pending.
    waitPhase(5);
    bus.i_freeze = 1'b1;
    waitPhase(10);
    applyStimulus(4'b0111);
    pulseLog.delete();
    waitPhase(50);
    checkOutput("freeze_levelTracks", bus.o_level, 4'b1000);
    waitPhase(5);
    bus.i_freeze = 1'b0;
    waitPhase(10);
    checkOutput("freeze_noPulse", pulseLog.size(), 0);
    waitPhase(10);
    checkOutput("freeze_pendCleared", pulseLog.size(), 0);
    applyStimulus(4'hF);
    waitPhase(50);

    // Debounce completes in the strobe cycle itself: move on that strobe.
    waitPhase(90);
    applyStimulus(4'b1110);
    waitPhase(99);
    checkOutput("coincide_levelAtStrobe", bus.o_level, 4'b0000);
    pulseLog.delete();
    tick();
    checkOutput("coincide_levelAfter", bus.o_level, 4'b0001);
    tick();
    checkOutput("coincide_nPulses", pulseLog.size(), 1);
    if (pulseLog.size() > 0)
      checkOutput("coincide_move", pulseLog[0].move, 4'b0001);
    applyStimulus(4'hF);
    waitPhase(50);
    pulseLog.delete();
    waitPhase(10);
    checkOutput("coincide_noDouble", pulseLog.size(), 0);

    // Asynchronous reset mid-debounce with up pending.
    waitPhase(10);
    applyStimulus(4'b1110);
    waitPhase(30);
    applyStimulus(4'b1100);
    waitPhase(36);
    checkOutput("reset_preLevel", bus.o_level, 4'b0001);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("reset_levelAsync", bus.o_level, 4'b0000);
    checkOutput("reset_moveAsync", bus.o_move, 4'b0000);
    applyStimulus(4'hF);
    repeat (3) tick();
    rst = 1'b0;
    pulseLog.delete();
    waitPhase(50);
    checkOutput("reset_levelAfter", bus.o_level, 4'b0000);
    waitPhase(10);
    checkOutput("reset_noPulse", pulseLog.size(), 0);

`ifdef BTN_REPEAT_EN
    // Hold left for 10 strobes: pulses on strobes 1, 3, 5, 7, 9.
    waitPhase(10);
    f0 = frameNum;
    applyStimulus(4'b1011);
    pulseLog.delete();
    repeat (10) waitPhase(10);
    applyStimulus(4'hF);
    checkOutput("repeat_nPulses", pulseLog.size(), 5);
    for (int j = 0; j < pulseLog.size() && j < 5; j++) begin
      checkOutput("repeat_move", pulseLog[j].move, 4'b0100);
      checkOutput("repeat_frame", pulseLog[j].frame - f0, 2 * j + 1);
    end
    pulseLog.delete();
    repeat (3) waitPhase(10);
    checkOutput("repeat_noneAfterRelease", pulseLog.size(), 0);
`else
    f0 = frameNum;
    checkOutput("frameCounterRunning", (f0 > 0) ? 1 : 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
